sysid_regs: RTL and testbench

Parametrised system-identification and housekeeping register file on an Avalon-MM slave, next generation of the fixed two-word system ID. Returns a system ID, a build timestamp, a free-running uptime counter with atomic 64-bit read, a software scratch register, a control register and up to eight user-defined constant words. It sits on the Nios II data master bus. Software uses it to check the hardware build, measure elapsed time and sanity-test bus access.

---
 rtl/sysid_pkg.sv | 33 +++
 rtl/sysid_regs_if.sv | 25 ++
 rtl/sysid_uptime.sv | 36 +++
 rtl/sysid_regs.sv | 104 ++++++++++
 tb/tb_sysid_regs.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sysid_pkg.sv
// Shared constants for the system-ID register file: word map, CONTROL bit
// positions and the user-word limit.
package sysid_pkg;

    localparam logic [3:0] ADDR_ID        = 4'd0;
    localparam logic [3:0] ADDR_TS        = 4'd1;
    localparam logic [3:0] ADDR_UP_LO     = 4'd2;
    localparam logic [3:0] ADDR_UP_HI     = 4'd3;
    localparam logic [3:0] ADDR_SCRATCH   = 4'd4;
    localparam logic [3:0] ADDR_CTRL      = 4'd5;
    localparam logic [3:0] ADDR_UCNT      = 4'd6;
    localparam logic [3:0] ADDR_USER_BASE = 4'd8;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_CLR_BIT = 1;

    localparam int MAX_USER = 8;

    // Byte-lane merge for partial writes: lanes with be[i]=0 keep old data.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] result;
        result = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sysid_regs_if.sv
// Avalon-MM slave bus bundle for the system-ID register file.
interface sysid_regs_if #(
    parameter int ADDR_W = 4
);
    // Handshake: no waitrequest, so read/write strobes are accepted in the
    // cycle they are presented; each accepted read yields exactly one
    // readdatavalid pulse with readdata on the following cycle.
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [3:0]        byteenable;
    logic [31:0]       readdata;
    logic              readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/sysid_uptime.sv
// 64-bit free-running uptime counter with enable/clear, plus the HI-word
// snapshot that makes a LO-then-HI read pair atomic.
module sysid_uptime (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic        clr,
    input  logic        snap,
    output logic [31:0] count_lo,
    output logic [31:0] snapshot
);

    logic [63:0] count;

    // Clear wins over increment; wrap at 2^64 is silent.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 64'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            snapshot <= '0;
        end else if (snap) begin
            snapshot <= count[63:32];
        end
    end

    assign count_lo = count[31:0];

endmodule

// File: rtl/sysid_regs.sv
// System-ID / housekeeping register file: ID, build timestamp, uptime,
// scratch, control and up to eight constant user words, 1-cycle read latency.
import sysid_pkg::*;

module sysid_regs #(
    parameter logic [31:0]              SYS_ID     = 32'h0000_0000,
    parameter logic [31:0]              TIMESTAMP  = 32'h0000_0000,
    parameter int                       ADDR_W     = 4,
    parameter int                       NUM_USER   = 0,
    parameter logic [MAX_USER*32-1:0]   USER_WORDS = '0
) (
    input  logic       clock,
    input  logic       reset,
    sysid_regs_if.slave bus
);

    if (NUM_USER < 0 || NUM_USER > MAX_USER) begin : g_bad_num_user
        $error("sysid_regs: NUM_USER must be in 0..8");
    end
    if (ADDR_W < 4) begin : g_bad_addr_w
        $error("sysid_regs: ADDR_W must be at least 4");
    end

    logic [3:0]  addr_lo;
    logic        addr_in_map;
    logic [2:0]  user_idx;
    logic        wr_scratch;
    logic        wr_ctrl;
    logic        clr_pulse;
    logic        snap_hi;
    logic        ctrl_en;
    logic [31:0] scratch;
    logic [31:0] count_lo;
    logic [31:0] snapshot;
    logic [31:0] rd_mux;

    // Only the low 16 words are mapped; anything above aliases to nothing.
    assign addr_lo     = bus.address[3:0];
    assign addr_in_map = ((bus.address >> 4) == '0);
    assign user_idx    = 3'(addr_lo - ADDR_USER_BASE);

    assign wr_scratch = bus.write && addr_in_map && (addr_lo == ADDR_SCRATCH);
    assign wr_ctrl    = bus.write && addr_in_map && (addr_lo == ADDR_CTRL) && bus.byteenable[0];
    assign clr_pulse  = wr_ctrl && bus.writedata[CTRL_CLR_BIT];
    assign snap_hi    = bus.read && addr_in_map && (addr_lo == ADDR_UP_LO);

    sysid_uptime u_uptime (
        .clock    (clock),
        .reset    (reset),
        .en       (ctrl_en),
        .clr      (clr_pulse),
        .snap     (snap_hi),
        .count_lo (count_lo),
        .snapshot (snapshot)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scratch <= '0;
            ctrl_en <= 1'b1;
        end else begin
            if (wr_scratch) begin
                scratch <= merge_bytes(scratch, bus.writedata, bus.byteenable);
            end
            if (wr_ctrl) begin
                ctrl_en <= bus.writedata[CTRL_EN_BIT];
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        if (addr_in_map) begin
            case (addr_lo)
                ADDR_ID:      rd_mux = SYS_ID;
                ADDR_TS:      rd_mux = TIMESTAMP;
                ADDR_UP_LO:   rd_mux = count_lo;
                ADDR_UP_HI:   rd_mux = snapshot;
                ADDR_SCRATCH: rd_mux = scratch;
                ADDR_CTRL:    rd_mux[CTRL_EN_BIT] = ctrl_en;
                ADDR_UCNT:    rd_mux = 32'(NUM_USER);
                default: begin
                    if (addr_lo >= ADDR_USER_BASE && int'(user_idx) < NUM_USER) begin
                        rd_mux = USER_WORDS[{user_idx, 5'd0} +: 32];
                    end
                end
            endcase
        end
    end

    // Read data reflects pre-edge state, so a concurrent write is not visible.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.readdata      <= '0;
            bus.readdatavalid <= 1'b0;
        end else begin
            bus.readdatavalid <= bus.read;
            if (bus.read) begin
                bus.readdata <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_sysid_regs.sv
// Bench for sysid_regs: directed vector table, atomic/clear/wrap/reset
// sequences and randomized traffic checked against a register-level model.
module tb_sysid_regs;
    import sysid_pkg::*;

    localparam int          ADDR_W    = 5;
    localparam int          NUM_USER  = 2;
    localparam logic [31:0] SYS_ID    = 32'h5372_CA51;
    localparam logic [31:0] TIMESTAMP = 32'h5372_C7D1;
    localparam logic [31:0] USER0     = 32'hC0DE_0000;
    localparam logic [31:0] USER1     = 32'hC0DE_0001;
    // Slot 2 is populated in the vector but must stay invisible (NUM_USER=2).
    localparam logic [255:0] USER_WORDS = {160'd0, 32'hBAD0_0002, USER1, USER0};

    logic clock = 1'b0;
    logic reset = 1'b1;

    sysid_regs_if #(.ADDR_W(ADDR_W)) bus ();

    sysid_regs #(
        .SYS_ID     (SYS_ID),
        .TIMESTAMP  (TIMESTAMP),
        .ADDR_W     (ADDR_W),
        .NUM_USER   (NUM_USER),
        .USER_WORDS (USER_WORDS)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    // Reference model state
    logic [63:0]  m_count;
    logic [31:0]  m_snap;
    logic [31:0]  m_scratch;
    logic         m_en;
    logic [31:0]  m_last;
    logic [255:0] m_user;
    logic [31:0]  exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          a;
        bit          rd;
        bit          wr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input int a);
        logic [31:0] r;
        r = 32'd0;
        case (a)
            0: r = SYS_ID;
            1: r = TIMESTAMP;
            2: r = m_count[31:0];
            3: r = m_snap;
            4: r = m_scratch;
            5: r = {31'd0, m_en};
            6: r = NUM_USER;
            default: begin
                if (a >= 8 && a < 8 + NUM_USER) begin
                    r = m_user[32*(a-8) +: 32];
                end
            end
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_count   = '0;
        m_snap    = '0;
        m_scratch = '0;
        m_en      = 1'b1;
        m_last    = '0;
        exp_q.delete();
    endtask

    // One bus cycle: drive, advance the model across the edge, then check.
    task automatic bus_cycle(input int a, input bit rd, input bit wr,
                             input logic [31:0] wd, input logic [3:0] be,
                             output bit seen_valid);
        bus.address    = ADDR_W'(a);
        bus.read       = rd;
        bus.write      = wr;
        bus.writedata  = wd;
        bus.byteenable = be;
        if (rd) exp_q.push_back(model_read(a));
        if (rd && a == 2) m_snap = m_count[63:32];
        if (wr && a == 5 && be[0] && wd[1]) m_count = '0;
        else if (m_en) m_count = m_count + 64'd1;
        if (wr && a == 4) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) m_scratch[8*i +: 8] = wd[8*i +: 8];
            end
        end
        if (wr && a == 5 && be[0]) m_en = wd[0];
        @(posedge clock);
        #1;
        bus.read  = 1'b0;
        bus.write = 1'b0;
        seen_valid = bus.readdatavalid;
        check("readdatavalid", 32'(bus.readdatavalid), 32'(rd));
        if (rd) begin
            m_last = exp_q.pop_front();
            check($sformatf("readdata@%0d", a), bus.readdata, m_last);
        end else begin
            check("readdata_hold", bus.readdata, m_last);
        end
    endtask

    task automatic rd_cycle(input int a);
        bit v;
        bus_cycle(a, 1'b1, 1'b0, 32'd0, 4'd0, v);
    endtask

    task automatic wr_cycle(input int a, input logic [31:0] wd, input logic [3:0] be);
        bit v;
        bus_cycle(a, 1'b0, 1'b1, wd, be, v);
    endtask

    task automatic idle_cycles(input int n);
        bit v;
        for (int i = 0; i < n; i++) bus_cycle(0, 1'b0, 1'b0, 32'd0, 4'd0, v);
    endtask

    task automatic preload(input logic [63:0] value);
        force dut.u_uptime.count = value;
        #1;
        release dut.u_uptime.count;
        m_count = value;
    endtask

    function automatic vec_t mk(input int a, input bit rd, input bit wr,
                                input logic [31:0] wd, input logic [3:0] be,
                                input logic [31:0] exp);
        vec_t v;
        v.a = a; v.rd = rd; v.wr = wr; v.wd = wd; v.be = be; v.exp = exp;
        return v;
    endfunction

    initial begin
        bit v1, v2, v3, v4;
        bit dummy;
        m_user = USER_WORDS;
        bus.address    = '0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.writedata  = '0;
        bus.byteenable = '0;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("reset_readdata", bus.readdata, 32'd0);
        check("reset_readdatavalid", 32'(bus.readdatavalid), 32'd0);
        reset = 1'b0;
        model_reset();

        // Directed vector table
        tbl.push_back(mk(0,  1, 0, 32'd0,          4'h0, SYS_ID));
        tbl.push_back(mk(1,  1, 0, 32'd0,          4'h0, TIMESTAMP));
        tbl.push_back(mk(4,  0, 1, 32'hDEAD_BEEF,  4'b0101, 32'd0));
        tbl.push_back(mk(4,  1, 0, 32'd0,          4'h0, 32'h00AD_00EF));
        tbl.push_back(mk(4,  1, 1, 32'h1122_3344,  4'hF, 32'h00AD_00EF));
        tbl.push_back(mk(4,  1, 0, 32'd0,          4'h0, 32'h1122_3344));
        tbl.push_back(mk(6,  1, 0, 32'd0,          4'h0, 32'd2));
        tbl.push_back(mk(8,  1, 0, 32'd0,          4'h0, USER0));
        tbl.push_back(mk(9,  1, 0, 32'd0,          4'h0, USER1));
        tbl.push_back(mk(10, 1, 0, 32'd0,          4'h0, 32'd0));
        tbl.push_back(mk(0,  0, 1, 32'hFFFF_FFFF,  4'hF, 32'd0));
        tbl.push_back(mk(0,  1, 0, 32'd0,          4'h0, SYS_ID));
        tbl.push_back(mk(7,  1, 0, 32'd0,          4'h0, 32'd0));
        tbl.push_back(mk(16, 1, 0, 32'd0,          4'h0, 32'd0));
        tbl.push_back(mk(24, 1, 0, 32'd0,          4'h0, 32'd0));
        tbl.push_back(mk(5,  1, 0, 32'd0,          4'h0, 32'd1));
        tbl.push_back(mk(5,  0, 1, 32'h0000_0002,  4'h1, 32'd0));
        tbl.push_back(mk(5,  1, 0, 32'd0,          4'h0, 32'd0));
        tbl.push_back(mk(2,  1, 0, 32'd0,          4'h0, 32'd0));
        tbl.push_back(mk(2,  1, 0, 32'd0,          4'h0, 32'd0));
        tbl.push_back(mk(5,  0, 1, 32'hFFFF_FFFF,  4'hE, 32'd0));
        tbl.push_back(mk(5,  1, 0, 32'd0,          4'h0, 32'd0));
        tbl.push_back(mk(2,  1, 0, 32'd0,          4'h0, 32'd0));
        tbl.push_back(mk(5,  0, 1, 32'h0000_0001,  4'h1, 32'd0));
        tbl.push_back(mk(5,  1, 0, 32'd0,          4'h0, 32'd1));
        tbl.push_back(mk(2,  1, 0, 32'd0,          4'h0, 32'd1));
        for (int i = 0; i < tbl.size(); i++) begin
            bus_cycle(tbl[i].a, tbl[i].rd, tbl[i].wr, tbl[i].wd, tbl[i].be, dummy);
            if (tbl[i].rd) check($sformatf("tbl[%0d]", i), bus.readdata, tbl[i].exp);
        end

        // Atomic LO/HI read across a 32-bit carry
        preload(64'h0000_0000_FFFF_FFFF);
        rd_cycle(2);
        check("atomic_lo", bus.readdata, 32'hFFFF_FFFF);
        rd_cycle(3);
        check("atomic_hi", bus.readdata, 32'd0);
        rd_cycle(2);
        rd_cycle(3);
        check("atomic_hi_next", bus.readdata, 32'd1);

        // Clear, then stop
        idle_cycles(5);
        rd_cycle(2);
        wr_cycle(5, 32'h0000_0003, 4'h1);
        rd_cycle(2);
        check("clr_then_read", bus.readdata, 32'd0);
        wr_cycle(5, 32'h0000_0000, 4'h1);
        idle_cycles(100);
        rd_cycle(2);
        check("frozen_count", bus.readdata, 32'd2);

        // 64-bit wrap
        wr_cycle(5, 32'h0000_0001, 4'h1);
        preload(64'hFFFF_FFFF_FFFF_FFFF);
        rd_cycle(2);
        check("wrap_lo", bus.readdata, 32'hFFFF_FFFF);
        rd_cycle(3);
        check("wrap_hi", bus.readdata, 32'hFFFF_FFFF);
        rd_cycle(2);
        check("wrap_after", bus.readdata, 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            int          a;
            bit          rd, wr;
            logic [31:0] wd;
            a  = $urandom_range(0, 31);
            rd = 1'($urandom_range(0, 1));
            wr = ($urandom_range(0, 3) == 0);
            wd = $urandom;
            if (a == 5) begin
                wd[1] = ($urandom_range(0, 7) == 0);
                wd[0] = ($urandom_range(0, 3) != 0);
            end
            bus_cycle(a, rd, wr, wd, 4'($urandom_range(0, 15)), dummy);
        end

        // Reset during a burst of back-to-back reads
        wr_cycle(5, 32'h0000_0001, 4'h1);
        wr_cycle(4, 32'hA5A5_A5A5, 4'hF);
        preload(64'h0000_0007_0000_0000);
        rd_cycle(2);
        bus_cycle(4, 1'b1, 1'b0, 32'd0, 4'd0, v1);
        bus_cycle(3, 1'b1, 1'b0, 32'd0, 4'd0, v2);
        check("pre_reset_snapshot", bus.readdata, 32'd7);
        bus.address = ADDR_W'(0);
        bus.read    = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("async_readdata", bus.readdata, 32'd0);
        check("async_readdatavalid", 32'(bus.readdatavalid), 32'd0);
        @(posedge clock);
        #1;
        v3 = bus.readdatavalid;
        bus.address = ADDR_W'(1);
        @(posedge clock);
        #1;
        v4 = bus.readdatavalid;
        check("valid_count", 32'(v1) + 32'(v2) + 32'(v3) + 32'(v4), 32'd2);
        check("reset_hold_readdata", bus.readdata, 32'd0);
        bus.read = 1'b0;
        reset    = 1'b0;
        model_reset();
        rd_cycle(4);
        check("post_reset_scratch", bus.readdata, 32'd0);
        rd_cycle(5);
        check("post_reset_ctrl", bus.readdata, 32'd1);
        rd_cycle(3);
        check("post_reset_snapshot", bus.readdata, 32'd0);
        rd_cycle(2);
        check("post_reset_count", bus.readdata, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
